// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline definitions: register classes, latencies,
// forwarding-select encodings and the scoreboard entry record.
package dlx_pipe_pkg;

    localparam int unsigned CLASS_GPR = 0;
    localparam int unsigned CLASS_FPR = 1;

    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

    // fwd_sel: 0 reads the register file, k selects result bus k (1 = newest)
    localparam int unsigned FWD_RF   = 0;
    localparam int unsigned FWD_BUS1 = 1;

    // Field widths cover MAX_LAT up to 255 and FWD_STAGES up to 16
    localparam int unsigned SB_CNT_W = 8;
    localparam int unsigned SB_AGE_W = 4;

    typedef struct packed {
        logic                busy;
        logic [SB_CNT_W-1:0] cnt;   // cycles until the result reaches bus 1
        logic [SB_AGE_W-1:0] age;   // cycles since the result reached bus 1
    } sb_entry_t;

endpackage

// File: rtl/dlx_sb_lookup.sv
// Per-source decode of one scoreboard entry into a RAW flag and a
// forwarding-bus select.
module dlx_sb_lookup
    import dlx_pipe_pkg::*;
#(
    parameter  int unsigned FWD_STAGES = 3,
    localparam int unsigned FWD_W      = $clog2(FWD_STAGES + 1)
) (
    input  sb_entry_t        ent_i,
    input  logic             use_i,
    output logic             raw_o,
    output logic [FWD_W-1:0] fwd_sel_o
);

    // Result still pending -> RAW; result on a bus -> forward from bus age+1
    always_comb begin
        raw_o     = 1'b0;
        fwd_sel_o = FWD_W'(FWD_RF);
        if (use_i && ent_i.busy) begin
            if (ent_i.cnt != '0) begin
                raw_o = 1'b1;
            end else begin
                fwd_sel_o = FWD_W'(ent_i.age) + FWD_W'(FWD_BUS1);
            end
        end
    end

endmodule

// File: rtl/dlx_hazard_scoreboard.sv
// ID-stage hazard/forwarding scoreboard with writeback-slot reservation.
// All state advances on the falling clock edge, like the ID/EX registers.
module dlx_hazard_scoreboard
    import dlx_pipe_pkg::*;
#(
    parameter  int unsigned NREG       = 32,
    parameter  int unsigned NCLASS     = 2,
    parameter  int unsigned FWD_STAGES = 3,
    parameter  int unsigned MAX_LAT    = 8,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned REG_W      = $clog2(NREG),
    localparam int unsigned CLS_W      = (NCLASS > 1) ? $clog2(NCLASS) : 1,
    localparam int unsigned LAT_W      = $clog2(MAX_LAT + 1),
    localparam int unsigned FWD_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_kill,
    input  logic [REG_W-1:0] src1_sel,
    input  logic [REG_W-1:0] src2_sel,
    input  logic             src1_use,
    input  logic             src2_use,
    input  logic [CLS_W-1:0] src_class,
    input  logic [REG_W-1:0] dst_sel,
    input  logic [CLS_W-1:0] dst_class,
    input  logic             dst_wr,
    input  logic [LAT_W-1:0] lat,
    output logic             stall,
    output logic             issue,
    output logic [FWD_W-1:0] fwd_sel1,
    output logic [FWD_W-1:0] fwd_sel2,
    output logic             lat_err,
    output logic [CNT_W-1:0] stall_count
);

    sb_entry_t        ent_q [NCLASS][NREG];
    sb_entry_t        ent_d [NCLASS][NREG];
    logic [MAX_LAT:1] res_q, res_d;
    logic             lat_err_q, lat_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             lat_bad;
    logic [LAT_W-1:0] lat_eff;
    logic             active;
    logic             dst_real;
    logic             wr_fire;
    logic             raw1, raw2, waw, struct_hz;
    sb_entry_t        src1_ent, src2_ent, dst_ent;

    assign src1_ent = ent_q[src_class][src1_sel];
    assign src2_ent = ent_q[src_class][src2_sel];
    assign dst_ent  = ent_q[dst_class][dst_sel];

    dlx_sb_lookup #(.FWD_STAGES(FWD_STAGES)) u_lookup1 (
        .ent_i     (src1_ent),
        .use_i     (src1_use),
        .raw_o     (raw1),
        .fwd_sel_o (fwd_sel1)
    );

    dlx_sb_lookup #(.FWD_STAGES(FWD_STAGES)) u_lookup2 (
        .ent_i     (src2_ent),
        .use_i     (src2_use),
        .raw_o     (raw2),
        .fwd_sel_o (fwd_sel2)
    );

    // Issue decision; a write to GPR r0 is discarded outright, so it neither
    // tracks an entry nor claims a writeback slot
    always_comb begin
        lat_bad   = (lat == '0) || (lat > LAT_W'(MAX_LAT));
        lat_eff   = lat_bad ? LAT_W'(MAX_LAT) : lat;
        active    = id_valid && !id_kill;
        dst_real  = dst_wr && !((dst_class == CLS_W'(CLASS_GPR)) && (dst_sel == '0));
        waw       = dst_real && dst_ent.busy && (dst_ent.cnt >= SB_CNT_W'(lat_eff));
        struct_hz = dst_real && res_q[lat_eff];
        stall     = active && (raw1 || raw2 || waw || struct_hz);
        issue     = active && !stall;
        wr_fire   = issue && dst_real;
    end

    // Entry aging, with a new issue overriding its destination entry
    always_comb begin
        for (int unsigned c = 0; c < NCLASS; c++) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                ent_d[c][r] = ent_q[c][r];
                if (ent_q[c][r].busy) begin
                    if (ent_q[c][r].cnt != '0) begin
                        ent_d[c][r].cnt = ent_q[c][r].cnt - SB_CNT_W'(1);
                    end else if (ent_q[c][r].age == SB_AGE_W'(FWD_STAGES - 1)) begin
                        ent_d[c][r] = '0;
                    end else begin
                        ent_d[c][r].age = ent_q[c][r].age + SB_AGE_W'(1);
                    end
                end
                if (wr_fire && (CLS_W'(c) == dst_class) && (REG_W'(r) == dst_sel)) begin
                    ent_d[c][r].busy = 1'b1;
                    ent_d[c][r].cnt  = SB_CNT_W'(lat_eff - LAT_W'(1));
                    ent_d[c][r].age  = '0;
                end
            end
        end
    end

    // Reservation shift; a latency-L issue lands at L-1 after this edge's shift,
    // and a latency-1 slot expires immediately so it is not stored
    always_comb begin
        res_d = {1'b0, res_q[MAX_LAT:2]};
        if (wr_fire && (lat_eff > LAT_W'(1))) begin
            res_d[lat_eff - LAT_W'(1)] = 1'b1;
        end
    end

    // Sticky latency error and saturating stall counter
    always_comb begin
        lat_err_d   = lat_err_q || (active && dst_wr && lat_bad);
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers, falling edge, asynchronous reset
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ent_q       <= '{default: '0};
            res_q       <= '0;
            lat_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            res_q       <= res_d;
            lat_err_q   <= lat_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign lat_err     = lat_err_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_dlx_hazard_scoreboard.sv
// Bench for dlx_hazard_scoreboard: directed scenarios plus random traffic,
// compared against a model based on absolute result-arrival times.
module tb_dlx_hazard_scoreboard;
    import dlx_pipe_pkg::*;

    localparam int FWD  = 3;
    localparam int MAXL = 8;
    localparam int NONE = -1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_kill = 1'b0;
    logic [4:0]  src1_sel = '0, src2_sel = '0, dst_sel = '0;
    logic        src1_use = 1'b0, src2_use = 1'b0, dst_wr = 1'b0;
    logic [0:0]  src_class = '0, dst_class = '0;
    logic [3:0]  lat = 4'd1;
    logic        stall, issue, lat_err;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: absolute cycle at which each register's result reaches bus 1,
    // plus the set of cycles already claimed on the writeback port
    int ready_t [2][32];
    bit res_m [int];
    int now_c;
    int scnt_m;
    bit lerr_m;
    bit e_stall, e_issue, e_wr;
    int e_f1, e_f2, e_lat;

    dlx_hazard_scoreboard #(
        .NREG(32), .NCLASS(2), .FWD_STAGES(FWD), .MAX_LAT(MAXL), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill),
        .src1_sel(src1_sel), .src2_sel(src2_sel),
        .src1_use(src1_use), .src2_use(src2_use), .src_class(src_class),
        .dst_sel(dst_sel), .dst_class(dst_class), .dst_wr(dst_wr), .lat(lat),
        .stall(stall), .issue(issue), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .lat_err(lat_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, now_c);
        end
    endtask

    function automatic void m_reset();
        foreach (ready_t[c, r]) ready_t[c][r] = NONE;
        res_m.delete();
        scnt_m = 0;
        lerr_m = 1'b0;
    endfunction

    function automatic void m_src(input int cls, input int sel, input bit use_s,
                                  output bit raw, output int fwd);
        int rt;
        rt  = ready_t[cls][sel];
        raw = 1'b0;
        fwd = 0;
        if (use_s && rt != NONE && now_c < rt + FWD) begin
            if (now_c < rt) raw = 1'b1;
            else            fwd = now_c - rt + 1;
        end
    endfunction

    function automatic void m_eval();
        bit raw1, raw2, active, bad, dreal, waw, st;
        int rt;
        m_src(int'(src_class), int'(src1_sel), src1_use, raw1, e_f1);
        m_src(int'(src_class), int'(src2_sel), src2_use, raw2, e_f2);
        active  = id_valid && !id_kill;
        bad     = (lat == 0) || (int'(lat) > MAXL);
        e_lat   = bad ? MAXL : int'(lat);
        dreal   = dst_wr && !(dst_class == 1'(CLASS_GPR) && dst_sel == 5'd0);
        rt      = ready_t[dst_class][dst_sel];
        waw     = dreal && rt != NONE && (rt - now_c) >= e_lat;
        st      = dreal && res_m.exists(now_c + e_lat);
        e_stall = active && (raw1 || raw2 || waw || st);
        e_issue = active && !e_stall;
        e_wr    = e_issue && dreal;
        if (active && dst_wr && bad) lerr_m = 1'b1;   // visible after the edge
    endfunction

    function automatic void m_update();
        if (e_wr) begin
            ready_t[dst_class][dst_sel] = now_c + e_lat;
            res_m[now_c + e_lat] = 1'b1;
        end
        if (e_stall && scnt_m < 65535) scnt_m++;
        now_c++;
    endfunction

    // One ID cycle: compare at the rising edge, advance the model at the falling edge
    task automatic step();
        bit lerr_before;
        @(posedge clk);
        lerr_before = lerr_m;
        m_eval();
        check("stall", int'(stall), int'(e_stall));
        check("issue", int'(issue), int'(e_issue));
        check("fwd1", int'(fwd_sel1), e_f1);
        check("fwd2", int'(fwd_sel2), e_f2);
        check("lat_err", int'(lat_err), int'(lerr_before));
        check("stall_count", int'(stall_count), scnt_m);
        @(negedge clk);
        m_update();
        #1;
    endtask

    task automatic set_in(input bit v, input bit k, input int s1, input bit u1,
                          input int s2, input bit u2, input int sc,
                          input int d, input int dc, input bit w, input int l);
        id_valid = v;  id_kill = k;
        src1_sel = 5'(s1); src1_use = u1;
        src2_sel = 5'(s2); src2_use = u2;
        src_class = 1'(sc);
        dst_sel = 5'(d); dst_class = 1'(dc); dst_wr = w; lat = 4'(l);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Pulse reset between edges; all outputs must clear while it is held
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_stall", int'(stall), 0);
        check("rst_fwd1", int'(fwd_sel1), 0);
        check("rst_fwd2", int'(fwd_sel2), 0);
        check("rst_cnt", int'(stall_count), 0);
        m_reset();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        now_c = 0;
        m_reset();
        #2;
        check("reset_stall", int'(stall), 0);
        check("reset_issue", int'(issue), 0);
        check("reset_fwd1", int'(fwd_sel1), 0);
        check("reset_lat_err", int'(lat_err), 0);
        check("reset_count", int'(stall_count), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // ALU chain on r3
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 3, CLASS_GPR, 1, LAT_ALU); step();
        set_in(1, 0, 3, 1, 1, 1, CLASS_GPR, 4, CLASS_GPR, 1, LAT_ALU); #1;
        check("alu_fwd_bus1", int'(fwd_sel1), 1);
        check("alu_nostall", int'(stall), 0);
        step();
        set_in(0, 0, 3, 1, 0, 0, CLASS_GPR, 0, CLASS_GPR, 0, 1); #1;
        check("alu_fwd_bus2", int'(fwd_sel1), 2);
        step();
        idle(); step();
        set_in(1, 0, 3, 1, 0, 0, CLASS_GPR, 0, CLASS_GPR, 0, 1); #1;
        check("alu_fwd_rf", int'(fwd_sel1), 0);
        step();

        // Load-use on r5
        idle(); do_reset();
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 5, CLASS_GPR, 1, LAT_LOAD); step();
        set_in(1, 0, 5, 1, 0, 0, CLASS_GPR, 6, CLASS_GPR, 1, LAT_ALU); #1;
        check("load_use_stall", int'(stall), 1);
        step();
        #1;
        check("load_use_go", int'(issue), 1);
        check("load_use_fwd", int'(fwd_sel1), 1);
        check("load_use_count", int'(stall_count), 1);
        step();

        // Class isolation: f3 busy, r3 free
        idle(); do_reset();
        set_in(1, 0, 0, 0, 0, 0, CLASS_FPR, 3, CLASS_FPR, 1, 4); step();
        set_in(1, 0, 3, 1, 0, 0, CLASS_GPR, 0, CLASS_GPR, 0, 1); #1;
        check("class_gpr_free", int'(stall), 0);
        step();
        set_in(1, 0, 3, 1, 0, 0, CLASS_FPR, 0, CLASS_GPR, 0, 1);
        repeat (4) step();

        // Structural then WAW on FPRs
        idle(); do_reset();
        set_in(1, 0, 0, 0, 0, 0, CLASS_FPR, 2, CLASS_FPR, 1, 4); step();
        set_in(1, 0, 0, 0, 0, 0, CLASS_FPR, 7, CLASS_FPR, 1, 3); #1;
        check("struct_stall", int'(stall), 1);
        step();
        #1;
        check("struct_issue", int'(issue), 1);
        step();
        set_in(1, 0, 0, 0, 0, 0, CLASS_FPR, 2, CLASS_FPR, 1, 1);
        repeat (4) step();

        // Killed slot with a RAW source
        idle(); do_reset();
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 3, CLASS_GPR, 1, 4); step();
        set_in(1, 1, 3, 1, 0, 0, CLASS_GPR, 9, CLASS_GPR, 1, 1); #1;
        check("kill_stall", int'(stall), 0);
        check("kill_issue", int'(issue), 0);
        step();

        // r0 writes are ignored
        idle(); do_reset();
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 0, CLASS_GPR, 1, LAT_ALU); step();
        set_in(1, 0, 0, 1, 0, 1, CLASS_GPR, 0, CLASS_GPR, 0, 1); #1;
        check("r0_fwd", int'(fwd_sel1), 0);
        check("r0_stall", int'(stall), 0);
        step();

        // Reset with three results in flight
        idle(); do_reset();
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 1, CLASS_GPR, 1, 6); step();
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 2, CLASS_GPR, 1, 7); step();
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 3, CLASS_GPR, 1, 8); step();
        set_in(1, 0, 1, 1, 2, 1, CLASS_GPR, 0, CLASS_GPR, 0, 1); #1;
        check("midflight_stall_pre", int'(stall), 1);
        do_reset();
        step();

        // Out-of-range latency
        idle(); do_reset();
        set_in(1, 0, 0, 0, 0, 0, CLASS_GPR, 6, CLASS_GPR, 1, 0); step();
        check("lat_err_set", int'(lat_err), 1);
        set_in(1, 0, 6, 1, 0, 0, CLASS_GPR, 0, CLASS_GPR, 0, 1);
        repeat (10) step();

        // Random traffic on a small register window to provoke hazards
        idle(); do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r, l;
            r = int'($urandom_range(0, 99));
            if (r < 3)       l = 0;
            else if (r < 5)  l = int'($urandom_range(9, 15));
            else if (r < 50) l = 1;
            else             l = int'($urandom_range(2, 8));
            set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                   int'($urandom_range(0, 7)), 1'($urandom),
                   int'($urandom_range(0, 7)), 1'($urandom),
                   int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                   $urandom_range(0, 9) < 7, l);
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
